// File: rtl/riscv_core_pkg.sv
// Shared core definitions: PC width, the NOP encoding and the fetch FSM states.
package riscv_core_pkg;

    localparam int PC_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, instr} words with a registered head and synchronous clear.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok = pop && (count != '0);
    assign empty  = (count == '0);
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= bump(wr_ptr);
            if (pop_ok) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    // Storage carries data only; validity lives entirely in count.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, issues word fetches, buffers responses and hands {instr, pc} to decode.
// Optional IFETCH_MISALIGN_CHECK_EN adds a sticky misaligned_pc flag that halts fetching.
module instruction_fetch
    import riscv_core_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
`ifdef IFETCH_MISALIGN_CHECK_EN
    output logic            misaligned_pc,
`endif
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instruction,
    output logic [PC_W-1:0] out_pc_value
);

    localparam int            CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

    fetch_state_e    state_p0, state_p1;
    logic [PC_W-1:0] fetch_pc_p0, fetch_pc_p1;
    logic [PC_W-1:0] rsp_pc_p0, rsp_pc_p1;
    logic [CW-1:0]   outst_p0, outst_p1;
    logic [CW-1:0]   discard_p0, discard_p1;
    logic [CW-1:0]   fifo_cnt_p0;
    logic            req_vld_p0, req_vld_p1;
    logic            mis_p0, mis_p1;

    logic [PC_W-1:0] redir_pc;
    logic            accept;
    logic            pop;
    logic            push;
    logic            flush;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_empty;
    logic [63:0]     fifo_head;

    assign accept = req_vld_p1 && imem_req_ready;
    assign pop    = instr_valid && instr_ready;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign redir_pc      = redirect_pc;
    assign mis_p0        = mis_p1 || (redirect_valid && (redirect_pc[1:0] != 2'b00));
    assign misaligned_pc = mis_p1;
`else
    assign redir_pc = redirect_pc & ~PC_W'(3);
    assign mis_p0   = 1'b0;
`endif

    always_comb begin
        state_p0    = state_p1;
        fetch_pc_p0 = fetch_pc_p1;
        rsp_pc_p0   = rsp_pc_p1;
        outst_p0    = outst_p1;
        discard_p0  = discard_p1;
        push        = 1'b0;
        flush       = 1'b0;
        if (redirect_valid) begin
            // Everything in flight becomes stale; a response landing now is one of them and is dropped.
            fetch_pc_p0 = redir_pc;
            rsp_pc_p0   = redir_pc;
            flush       = 1'b1;
            if (state_p1 == DRAIN) begin
                discard_p0 = discard_p1 - CW'(imem_rsp_valid);
            end else begin
                discard_p0 = outst_p1 + CW'(accept) - CW'(imem_rsp_valid);
                outst_p0   = '0;
            end
            state_p0 = (discard_p0 == '0) ? FETCH : DRAIN;
        end else begin
            unique case (state_p1)
                BOOT: state_p0 = FETCH;
                FETCH: begin
                    push = imem_rsp_valid;
                    if (accept) fetch_pc_p0 = fetch_pc_p1 + PC_W'(4);
                    if (push)   rsp_pc_p0   = rsp_pc_p1 + PC_W'(4);
                    outst_p0 = outst_p1 + CW'(accept) - CW'(imem_rsp_valid);
                end
                DRAIN: begin
                    discard_p0 = discard_p1 - CW'(imem_rsp_valid);
                    if (discard_p0 == '0) state_p0 = FETCH;
                end
                default: state_p0 = BOOT;
            endcase
        end
        // Request valid is registered, so evaluate the issue rule on next-cycle occupancy.
        fifo_cnt_p0 = flush ? '0 : fifo_cnt + CW'(push) - CW'(pop);
        req_vld_p0  = (state_p0 == FETCH) && !mis_p0 &&
                      (({1'b0, outst_p0} + {1'b0, fifo_cnt_p0}) < DEPTH_LIM);
    end

    // ---- control / PC registers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p1    <= BOOT;
            fetch_pc_p1 <= RESET_PC;
            rsp_pc_p1   <= RESET_PC;
            outst_p1    <= '0;
            discard_p1  <= '0;
            req_vld_p1  <= 1'b0;
            mis_p1      <= 1'b0;
        end else begin
            state_p1    <= state_p0;
            fetch_pc_p1 <= fetch_pc_p0;
            rsp_pc_p1   <= rsp_pc_p0;
            outst_p1    <= outst_p0;
            discard_p1  <= discard_p0;
            req_vld_p1  <= req_vld_p0;
            mis_p1      <= mis_p0;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata ({rsp_pc_p1, imem_rsp_data}),
        .rdata (fifo_head),
        .count (fifo_cnt),
        .empty (fifo_empty)
    );

    // ---- outputs ----
    assign imem_req_valid = req_vld_p1;
    assign imem_req_addr  = fetch_pc_p1;
    assign instr_valid    = !fifo_empty;
    assign instruction    = instr_valid ? fifo_head[31:0]  : NOP_INSTR;
    assign out_pc_value   = instr_valid ? fifo_head[63:32] : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a zero-wait in-order memory model and a decode log.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instruction;
    logic [31:0] out_pc_value;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        misaligned_pc;
`endif

    logic        rsp_en = 1'b1;
    logic [31:0] mem_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];
    int          checks = 0;
    int          errors = 0;

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef IFETCH_MISALIGN_CHECK_EN
        .misaligned_pc  (misaligned_pc),
`endif
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .out_pc_value   (out_pc_value)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: log handshakes before the edge, then advance the memory model after it.
    task automatic tick();
        logic        acc;
        logic        rfire;
        logic [31:0] aaddr;
        acc   = imem_req_valid && imem_req_ready;
        aaddr = imem_req_addr;
        rfire = imem_rsp_valid;
        if (instr_valid && instr_ready) begin
            got_pc.push_back(out_pc_value);
            got_ins.push_back(instruction);
        end
        @(posedge clk);
        #1;
        if (rfire && mem_q.size() > 0) void'(mem_q.pop_front());
        if (acc) begin
            mem_q.push_back(aaddr);
            acc_log.push_back(aaddr);
        end
        imem_rsp_valid = rsp_en && (mem_q.size() > 0);
        imem_rsp_data  = imem_rsp_valid ? data_of(mem_q[0]) : 32'h0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic release_reset();
        mem_q.delete();
        acc_log.delete();
        got_pc.delete();
        got_ins.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        release_reset();
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        #2 rst = 1'b0;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instruction", instruction, 32'h0000_0013);
        check("rst_out_pc", out_pc_value, 32'h0);
`ifdef IFETCH_MISALIGN_CHECK_EN
        check("rst_misaligned", {31'b0, misaligned_pc}, 32'd0);
`endif
        release_reset();

        // Streaming with zero-wait memory and decode always ready
        tick();
        check("boot_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("boot_req_addr", imem_req_addr, 32'h0);
        tick();
        check("rsp_cycle_no_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        check("first_instr_valid", {31'b0, instr_valid}, 32'd1);
        check("first_pc", out_pc_value, 32'h0);
        check("first_instr", instruction, 32'hDEAD_0000);
        ticks(12);
        for (int i = 0; i < 4; i++) begin
            check("stream_pc", got_pc[i], 32'(4 * i));
            check("stream_instr", got_ins[i], data_of(32'(4 * i)));
            check("stream_req", acc_log[i], 32'(4 * i));
        end

        // Decode stalled: exactly FIFO_DEPTH requests, then resume in order
        instr_ready = 1'b0;
        do_reset();
        ticks(10);
        check("stall_req_count", 32'(acc_log.size()), 32'd2);
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("stall_head_pc", out_pc_value, 32'h0);
        check("stall_no_pop", 32'(got_pc.size()), 32'd0);
        instr_ready = 1'b1;
        ticks(12);
        for (int i = 0; i < 4; i++) check("resume_pc", got_pc[i], 32'(4 * i));

        // Redirect with two requests outstanding
        rsp_en = 1'b0;
        do_reset();
        ticks(3);
        check("two_outst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        redirect(32'h0000_0100);
        check("drain_req_valid", {31'b0, imem_req_valid}, 32'd0);
        rsp_en = 1'b1;
        ticks(2);
        check("drain_instr_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        check("post_drain_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("post_drain_req_addr", imem_req_addr, 32'h0000_0100);
        ticks(6);
        check("redir_req_log", acc_log[2], 32'h0000_0100);
        check("redir_first_pc", got_pc[0], 32'h0000_0100);
        check("redir_first_instr", got_ins[0], 32'hDEAD_0100);

        // Redirect coinciding with a response and a pop
        do_reset();
        ticks(3);
        check("pre_redir_head", out_pc_value, 32'h0);
        redirect(32'h0000_0040);
        check("coinc_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("coinc_req_addr", imem_req_addr, 32'h0000_0040);
        ticks(8);
        check("coinc_popped", got_pc[0], 32'h0);
        check("coinc_next_pc", got_pc[1], 32'h0000_0040);
        check("coinc_next_instr", got_ins[1], 32'hDEAD_0040);
        check("coinc_follow_pc", got_pc[2], 32'h0000_0044);

        // Memory not ready: address held, redirect withdraws the pending request
        imem_req_ready = 1'b0;
        do_reset();
        tick();
        check("hold_addr_c1", imem_req_addr, 32'h0);
        tick();
        check("hold_addr_c2", imem_req_addr, 32'h0);
        check("hold_valid_c2", {31'b0, imem_req_valid}, 32'd1);
        redirect(32'h0000_0200);
        check("withdraw_addr", imem_req_addr, 32'h0000_0200);
        ticks(2);
        check("new_addr_stable", imem_req_addr, 32'h0000_0200);
        check("no_accept_yet", 32'(acc_log.size()), 32'd0);
        imem_req_ready = 1'b1;
        ticks(5);
        check("withdraw_first_req", acc_log[0], 32'h0000_0200);
        check("withdraw_first_pc", got_pc[0], 32'h0000_0200);

        // Asynchronous reset in the middle of DRAIN
        rsp_en = 1'b0;
        do_reset();
        ticks(3);
        redirect(32'h0000_0300);
        check("drain_addr", imem_req_addr, 32'h0000_0300);
        #2 rst = 1'b0;
        #1;
        check("async_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("async_req_addr", imem_req_addr, 32'h0);
        check("async_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("async_instruction", instruction, 32'h0000_0013);
        rsp_en = 1'b1;
        release_reset();
        tick();
        check("after_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("after_rst_req_addr", imem_req_addr, 32'h0);
        ticks(4);
        check("after_rst_first_pc", got_pc[0], 32'h0);

        // Misaligned redirect target
        imem_req_ready = 1'b0;
        do_reset();
        tick();
        redirect(32'h0000_0102);
`ifdef IFETCH_MISALIGN_CHECK_EN
        check("misalign_flag", {31'b0, misaligned_pc}, 32'd1);
        check("misalign_no_req", {31'b0, imem_req_valid}, 32'd0);
        ticks(3);
        check("misalign_sticky", {31'b0, misaligned_pc}, 32'd1);
`else
        check("align_forced_addr", imem_req_addr, 32'h0000_0100);
        check("align_forced_valid", {31'b0, imem_req_valid}, 32'd1);
`endif
        imem_req_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
